// File: rtl/nmac_pkg.sv
// Shared widths and the controller state type for the nibble MAC sequencer.
package nmac_pkg;

  localparam int unsigned NIB_W     = 4;
  localparam int unsigned DATA_W    = 2 * NIB_W;
  localparam int unsigned ACC_W     = 24;
  localparam int unsigned OUT_BYTES = 3;

  typedef enum logic [2:0] {
    LD_IN_HI,
    LD_IN_LO,
    LD_W_HI,
    LD_W_LO,
    MAC,
    OUT0,
    OUT1,
    OUT2
  } nmac_state_t;

endpackage

// File: rtl/nmac_byte_serializer.sv
// Captures a 24-bit word on load and presents it as three bytes, LSB first,
// over a valid/ready handshake.
module nmac_byte_serializer
  import nmac_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] word,
  input  logic             load,
  output logic [7:0]       data_out,
  output logic             valid,
  input  logic             ready
);

  logic [ACC_W-1:0] word_q, word_d;
  logic [1:0]       left_q, left_d;

  assign valid    = (left_q != '0);
  assign data_out = valid ? word_q[7:0] : '0;

  always_comb begin
    word_d = word_q;
    left_d = left_q;
    if (load) begin
      word_d = word;
      left_d = 2'(OUT_BYTES);
    end else if (valid && ready) begin
      word_d = word_q >> 8;
      left_d = left_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      left_q <= '0;
    end else begin
      word_q <= word_d;
      left_q <= left_d;
    end
  end

endmodule

// File: rtl/nibble_mac_sequencer.sv
// Sequences four nibble loads into an 8x8 unsigned multiply-accumulate and
// streams the 24-bit accumulator out as three bytes.
module nibble_mac_sequencer
  import nmac_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [NIB_W-1:0] nib_in,
  input  logic             nib_valid,
  output logic             nib_ready,
  input  logic             cmd_acc,
  output logic [7:0]       res_byte,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic [7:0]       mac_count
);

  nmac_state_t         state_q, state_d;
  logic [DATA_W-1:0]   in_q, in_d;
  logic [DATA_W-1:0]   w_q, w_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                clr_q, clr_d;
  logic                ser_load;
  logic                nib_hs;
  logic                res_hs;
  logic [2*DATA_W-1:0] product;

  assign nib_hs    = nib_valid && nib_ready;
  assign res_hs    = res_valid && res_ready;
  assign product   = {{DATA_W{1'b0}}, in_q} * {{DATA_W{1'b0}}, w_q};
  assign busy      = (state_q != LD_IN_HI);
  assign mac_count = cnt_q;

  always_comb begin
    state_d   = state_q;
    in_d      = in_q;
    w_d       = w_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    clr_d     = clr_q;
    nib_ready = 1'b0;
    ser_load  = 1'b0;
    unique case (state_q)
      LD_IN_HI: begin
        nib_ready = 1'b1;
        if (nib_hs) begin
          in_d[DATA_W-1:NIB_W] = nib_in;
          clr_d                = ~cmd_acc;
          state_d              = LD_IN_LO;
        end
      end
      LD_IN_LO: begin
        nib_ready = 1'b1;
        if (nib_hs) begin
          in_d[NIB_W-1:0] = nib_in;
          state_d         = LD_W_HI;
        end
      end
      LD_W_HI: begin
        nib_ready = 1'b1;
        if (nib_hs) begin
          w_d[DATA_W-1:NIB_W] = nib_in;
          state_d             = LD_W_LO;
        end
      end
      LD_W_LO: begin
        nib_ready = 1'b1;
        if (nib_hs) begin
          w_d[NIB_W-1:0] = nib_in;
          state_d        = MAC;
        end
      end
      MAC: begin
        acc_d    = (clr_q ? '0 : acc_q) + ACC_W'(product);
        cnt_d    = clr_q ? 8'd1 : ((cnt_q == '1) ? cnt_q : cnt_q + 8'd1);
        // The serializer captures the freshly accumulated value, not acc_q.
        ser_load = 1'b1;
        state_d  = OUT0;
      end
      OUT0: if (res_hs) state_d = OUT1;
      OUT1: if (res_hs) state_d = OUT2;
      OUT2: if (res_hs) state_d = LD_IN_HI;
      default: state_d = LD_IN_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LD_IN_HI;
      in_q    <= '0;
      w_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      w_q     <= w_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
    end
  end

  nmac_byte_serializer u_ser (
    .clk      (clk),
    .rst      (rst),
    .word     (acc_d),
    .load     (ser_load),
    .data_out (res_byte),
    .valid    (res_valid),
    .ready    (res_ready)
  );

endmodule

// File: tb/tb_nibble_mac_sequencer.sv
// Scoreboard bench: ops are modelled arithmetically, expected bytes queued,
// and a monitor compares every accepted output byte.
module tb_nibble_mac_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] nib_in;
  logic       nib_valid;
  logic       nib_ready;
  logic       cmd_acc;
  logic [7:0] res_byte;
  logic       res_valid;
  logic       res_ready;
  logic       busy;
  logic [7:0] mac_count;

  typedef struct {
    logic [7:0] b;
    logic [7:0] mc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          passes = 0;
  int unsigned acc_m  = 0;
  int unsigned cnt_m  = 0;

  always #5 clk = ~clk;

  nibble_mac_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .nib_in    (nib_in),
    .nib_valid (nib_valid),
    .nib_ready (nib_ready),
    .cmd_acc   (cmd_acc),
    .res_byte  (res_byte),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .mac_count (mac_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every accepted byte is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_byte", 32'(res_byte), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("res_byte", 32'(res_byte), 32'(e.b));
          chk("mac_count", 32'(mac_count), 32'(e.mc));
        end
      end
      if (!res_valid) chk("idle_byte_zero", 32'(res_byte), 32'h0);
    end
  end

  // Entered and left at posedge+1.
  task automatic send_nib(input logic [3:0] n, input logic cmd, input bit gaps);
    int unsigned waited = 0;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        nib_valid = 1'b0;
        nib_in    = 4'($urandom);
        @(posedge clk); #1;
      end
    end
    nib_valid = 1'b1;
    nib_in    = n;
    cmd_acc   = cmd;
    forever begin
      @(negedge clk);
      if (nib_ready) break;
      waited++;
      if (waited > 64) begin
        chk("nib_ready_timeout", 32'd0, 32'd1);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    nib_valid = 1'b0;
    nib_in    = 4'($urandom);
    cmd_acc   = 1'($urandom);
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] w, input logic acc, input bit gaps);
    exp_t e;
    if (!acc) begin
      acc_m = 0;
      cnt_m = 0;
    end
    acc_m = (acc_m + int'(a) * int'(w)) % (1 << 24);
    cnt_m = (cnt_m >= 255) ? 255 : cnt_m + 1;
    for (int i = 0; i < 3; i++) begin
      e.b  = 8'(acc_m >> (8 * i));
      e.mc = 8'(cnt_m);
      sb.push_back(e);
    end
    send_nib(a[7:4], acc, gaps);
    send_nib(a[3:0], 1'($urandom), gaps);
    send_nib(w[7:4], 1'($urandom), gaps);
    send_nib(w[3:0], 1'($urandom), gaps);
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    forever begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) break;
      n++;
      if (n > 100) begin
        chk("idle_timeout", 32'(busy), 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_res_valid();
    int unsigned n = 0;
    forever begin
      @(posedge clk); #1;
      if (res_valid) break;
      n++;
      if (n > 20) begin
        chk("res_valid_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  initial begin
    logic [7:0] hold_b;
    rst       = 1'b1;
    nib_in    = '0;
    nib_valid = 1'b0;
    cmd_acc   = 1'b0;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_nib_ready", 32'(nib_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_byte", 32'(res_byte), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mac_count", 32'(mac_count), 32'd0);
    @(posedge clk); #1;

    // Clear op then accumulate op: A8,03,00 then A9,01,01.
    do_op(8'h12, 8'h34, 1'b0, 1'b0);
    wait_idle();
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    wait_idle();
    chk("acc_after_two", acc_m, 32'h0001_01A9);

    // Backpressure in OUT1 with ignored nibble pulses.
    res_ready = 1'b0;
    do_op(8'h12, 8'h34, 1'b0, 1'b0);
    hold_b = 8'(acc_m >> 8);
    wait_res_valid();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    repeat (5) begin
      nib_valid = 1'($urandom);
      nib_in    = 4'($urandom);
      @(negedge clk);
      chk("stall_valid", 32'(res_valid), 32'd1);
      chk("stall_byte", 32'(res_byte), 32'(hold_b));
      chk("stall_nib_ready", 32'(nib_ready), 32'd0);
      @(posedge clk); #1;
    end
    nib_valid = 1'b0;
    res_ready = 1'b1;
    wait_idle();

    // 259 ops of 0xFF*0xFF: accumulator wraps, mac_count saturates.
    for (int i = 0; i < 259; i++) begin
      do_op(8'hFF, 8'hFF, (i != 0), 1'b0);
      wait_idle();
    end
    chk("wrap_acc_model", acc_m, 32'h0000_FB03);

    // Reset during OUT1 discards the rest of the op.
    res_ready = 1'b0;
    do_op(8'h12, 8'h34, 1'b1, 1'b0);
    wait_res_valid();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    acc_m = 0;
    cnt_m = 0;
    @(negedge clk);
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_nib_ready", 32'(nib_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_mac_count", 32'(mac_count), 32'd0);
    @(posedge clk); #1;
    res_ready = 1'b1;
    do_op(8'h02, 8'h03, 1'b1, 1'b0);
    wait_idle();

    // Gappy nibble delivery, then random ops.
    do_op(8'h80, 8'h80, 1'b0, 1'b1);
    wait_idle();
    for (int i = 0; i < 24; i++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      wait_idle();
    end

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
